// File: rtl/player_input_conditioner.sv
// rtl/player_input_conditioner.sv - debounce, press pulse and false-start flags for two player buttons
// Each channel: 2-FF synchronizer, four-state debounce FSM with stable-sample counter, foul flag.

module player_input_conditioner #(
  parameter int CLOCK_FREQ      = 1000,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic player_1_in_n,
  input  logic player_2_in_n,
  input  logic armed_in,
  input  logic clear_fouls_in,
  output logic req1_out,
  output logic req2_out,
  output logic press1_out,
  output logic press2_out,
  output logic foul1_out,
  output logic foul2_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || CLOCK_FREQ < 1) begin : g_bad_param
    $error("player_input_conditioner: DEBOUNCE_CYCLES must be 1..255 and CLOCK_FREQ positive");
  end

  logic [1:0] w_raw_n;
  logic [1:0] w_req;
  logic [1:0] w_press;
  logic [1:0] w_foul;

  assign w_raw_n = {player_2_in_n, player_1_in_n};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_press;
    logic          r_foul;
    logic          w_level;
    logic          w_mismatch;
    logic          w_done;
    logic          w_press_evt;

    // Inversion happens before the synchronizer so reset (0) means released.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= ~w_raw_n[g];
        r_sync2 <= r_sync1;
      end
    end

    assign w_level     = (r_state == PRESSED) || (r_state == RELEASE_CHK);
    assign w_mismatch  = (r_sync2 != w_level);
    assign w_done      = w_mismatch && (r_cnt == CNT_LAST);
    assign w_press_evt = w_done && !w_level;

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        RELEASED: begin
          if (w_done)          w_state_nxt = PRESSED;
          else if (w_mismatch) w_state_nxt = PRESS_CHK;
        end
        PRESS_CHK: begin
          if (w_done)           w_state_nxt = PRESSED;
          else if (!w_mismatch) w_state_nxt = RELEASED;
        end
        PRESSED: begin
          if (w_done)          w_state_nxt = RELEASED;
          else if (w_mismatch) w_state_nxt = RELEASE_CHK;
        end
        RELEASE_CHK: begin
          if (w_done)           w_state_nxt = RELEASED;
          else if (!w_mismatch) w_state_nxt = PRESSED;
        end
        default: w_state_nxt = RELEASED;
      endcase
    end

    // A new foul on the press edge outranks a coincident clear.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= RELEASED;
        r_cnt   <= '0;
        r_press <= 1'b0;
        r_foul  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= (w_mismatch && !w_done) ? r_cnt + 1'b1 : '0;
        r_press <= w_press_evt && armed_in && !r_foul;
        r_foul  <= (w_press_evt && !armed_in) || (r_foul && !clear_fouls_in);
      end
    end

    assign w_req[g]   = w_level;
    assign w_press[g] = r_press;
    assign w_foul[g]  = r_foul;
  end

  assign req1_out   = w_req[0];
  assign req2_out   = w_req[1];
  assign press1_out = w_press[0];
  assign press2_out = w_press[1];
  assign foul1_out  = w_foul[0];
  assign foul2_out  = w_foul[1];

endmodule

// File: tb/tb_player_input_conditioner.sv
// tb/tb_player_input_conditioner.sv - scoreboard bench for player_input_conditioner
// Reference model judges each debounce flip from a window of the last D synchronized samples.

module tb_player_input_conditioner;

  localparam int D   = 4;
  localparam int REQ1 = 0;
  localparam int REQ2 = 1;
  localparam int PR1  = 2;
  localparam int PR2  = 3;
  localparam int F1   = 4;
  localparam int F2   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic p1_n  = 1'b1;
  logic p2_n  = 1'b1;
  logic armed = 1'b1;
  logic clear = 1'b0;

  logic req1, req2, press1, press2, foul1, foul2;
  logic [5:0] w_obs;
  assign w_obs = {foul2, foul1, press2, press1, req2, req1};

  player_input_conditioner #(.CLOCK_FREQ(1000), .DEBOUNCE_CYCLES(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .player_1_in_n (p1_n),
    .player_2_in_n (p2_n),
    .armed_in      (armed),
    .clear_fouls_in(clear),
    .req1_out      (req1),
    .req2_out      (req2),
    .press1_out    (press1),
    .press2_out    (press2),
    .foul1_out     (foul1),
    .foul2_out     (foul2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: history of inverted raw samples, one bit per clock edge.
  logic [1:0][31:0] m_s, mn_s;
  logic [1:0]       m_req, mn_req, m_foul, mn_foul, mn_press;
  logic [1:0]       w_raw_n;
  logic [5:0]       sb_q[$];

  assign w_raw_n = {p2_n, p1_n};

  always_comb begin
    mn_s     = m_s;
    mn_req   = m_req;
    mn_foul  = m_foul;
    mn_press = '0;
    for (int p = 0; p < 2; p++) begin
      logic [D-1:0] win;
      logic rise, fall;
      win  = m_s[p][D:1];
      rise = !m_req[p] && (&win);
      fall =  m_req[p] && !(|win);
      if (reset) begin
        mn_s[p]     = '0;
        mn_req[p]   = 1'b0;
        mn_foul[p]  = 1'b0;
        mn_press[p] = 1'b0;
      end else begin
        mn_s[p]     = {m_s[p][30:0], ~w_raw_n[p]};
        mn_req[p]   = m_req[p] ^ (rise | fall);
        mn_press[p] = rise && armed && !m_foul[p];
        mn_foul[p]  = (rise && !armed) || (m_foul[p] && !clear);
      end
    end
  end

  always @(posedge clk) begin
    m_s    <= mn_s;
    m_req  <= mn_req;
    m_foul <= mn_foul;
    sb_q.push_back({mn_foul, mn_press, mn_req});
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) chk("sb_outputs", {26'd0, w_obs}, {26'd0, sb_q.pop_front()});
  endtask

  task automatic wait_sig(input int sel, input logic lvl, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (w_obs[sel] == lvl) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int h1, h2;
    h1 = 0;
    h2 = 0;

    repeat (3) cyc();
    chk("reset_state", {26'd0, w_obs}, 32'd0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("idle_state", {26'd0, w_obs}, 32'd0);

    // 1: clean press held 20 cycles
    p1_n = 1'b0;
    wait_sig(REQ1, 1'b1, n);
    chk("t1_req1_latency", n, 6);
    chk("t1_press1", w_obs[PR1], 1);
    cyc();
    chk("t1_press1_single", w_obs[PR1], 0);
    repeat (13) cyc();
    chk("t1_req1_held", w_obs[REQ1], 1);
    chk("t1_foul1", w_obs[F1], 0);
    p1_n = 1'b1;
    wait_sig(REQ1, 1'b0, n);
    chk("t1_release_latency", n, 6);
    repeat (2) cyc();

    // 2: bounce every 2 cycles, then settle low
    for (int i = 0; i < 12; i++) begin
      p1_n = ((i / 2) % 2) != 0;
      cyc();
      chk("t2_no_req_bounce", w_obs[REQ1], 0);
    end
    p1_n = 1'b0;
    wait_sig(REQ1, 1'b1, n);
    chk("t2_req1_latency", n, 6);
    p1_n = 1'b1;
    wait_sig(REQ1, 1'b0, n);
    repeat (2) cyc();

    // 3: false start on p2, stays fouled until cleared
    armed = 1'b0;
    p2_n  = 1'b0;
    wait_sig(REQ2, 1'b1, n);
    chk("t3_foul2_set", w_obs[F2], 1);
    chk("t3_no_press2", w_obs[PR2], 0);
    p2_n = 1'b1;
    wait_sig(REQ2, 1'b0, n);
    armed = 1'b1;
    p2_n  = 1'b0;
    wait_sig(REQ2, 1'b1, n);
    chk("t3_fouled_no_press2", w_obs[PR2], 0);
    chk("t3_foul2_sticky", w_obs[F2], 1);
    p2_n = 1'b1;
    wait_sig(REQ2, 1'b0, n);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t3_foul2_cleared", w_obs[F2], 0);
    p2_n = 1'b0;
    wait_sig(REQ2, 1'b1, n);
    chk("t3_press2_after_clear", w_obs[PR2], 1);
    p2_n = 1'b1;
    wait_sig(REQ2, 1'b0, n);
    repeat (2) cyc();

    // 4: simultaneous presses
    p1_n = 1'b0;
    p2_n = 1'b0;
    wait_sig(REQ1, 1'b1, n);
    chk("t4_req1_latency", n, 6);
    chk("t4_req2_together", w_obs[REQ2], 1);
    chk("t4_press_both", {30'd0, w_obs[PR2], w_obs[PR1]}, 32'd3);
    p1_n = 1'b1;
    p2_n = 1'b1;
    wait_sig(REQ1, 1'b0, n);
    repeat (2) cyc();

    // 5: reset in mid-debounce while p1 held
    p1_n = 1'b0;
    repeat (4) cyc();
    chk("t5_pre_reset", w_obs[REQ1], 0);
    reset = 1'b1;
    cyc();
    chk("t5_in_reset_a", {26'd0, w_obs}, 32'd0);
    cyc();
    chk("t5_in_reset_b", {26'd0, w_obs}, 32'd0);
    reset = 1'b0;
    wait_sig(PR1, 1'b1, n);
    chk("t5_press1_after_reset", n, 6);
    p1_n = 1'b1;
    wait_sig(REQ1, 1'b0, n);
    repeat (2) cyc();

    // 6: clear coincident with a new foul
    armed = 1'b0;
    p1_n  = 1'b0;
    repeat (5) cyc();
    chk("t6_pre_event", w_obs[REQ1], 0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t6_req1_rise", w_obs[REQ1], 1);
    chk("t6_foul1_set_wins", w_obs[F1], 1);
    chk("t6_no_press1", w_obs[PR1], 0);
    p1_n  = 1'b1;
    armed = 1'b1;
    wait_sig(REQ1, 1'b0, n);

    // random mix, checked by the scoreboard only
    for (int i = 0; i < 400; i++) begin
      if (h1 == 0) begin
        p1_n = 1'($urandom_range(0, 1));
        h1   = int'($urandom_range(1, 9));
      end else h1--;
      if (h2 == 0) begin
        p2_n = 1'($urandom_range(0, 1));
        h2   = int'($urandom_range(1, 9));
      end else h2--;
      if ($urandom_range(0, 19) == 0) armed = ~armed;
      clear = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 149) == 0);
      cyc();
    end
    reset = 1'b0;
    clear = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
